fifo_uart_tx: RTL and testbench

Drain stage on the read side of the 32×8 byte FIFO. While `Run` is high and the FIFO is not empty, it pops one byte at a time through the FIFO's `Enable`/`Read_Write` port. Each byte is sent LSB-first as an asynchronous serial frame on `Tx`. The block is the FIFO's only reader; the write side belongs to the upstream producer.

---
 rtl/fifo_uart_pkg.sv | 14 +
 rtl/fifo_uart_tx_baud.sv | 29 ++
 rtl/fifo_uart_tx.sv | 150 +++++++++++++++
 tb/tb_fifo_uart_tx.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-draining UART transmitter.
// FIFO_UART_TX_PARITY_EN adds the PARITY state to the state enum.
package fifo_uart_pkg;

    localparam int   DATA_BITS = 8;
    localparam logic FIFO_RD   = 1'b0;

`ifdef FIFO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, REQ, LOAD, START, DATA, PARITY, STOP} tx_state_t;
`else
    typedef enum logic [2:0] {IDLE, REQ, LOAD, START, DATA, STOP} tx_state_t;
`endif

endpackage

// File: rtl/fifo_uart_tx_baud.sv
// Bit-period tick generator: Tick is high on the last cycle of every bit period.
// Unaffected by FIFO_UART_TX_PARITY_EN.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic CLK,
    input  logic Reset,
    input  logic Clear,
    output logic Tick
);

    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            count_reg <= '0;
        end else if (Clear || (count_reg == LAST)) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign Tick = (count_reg == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains the byte FIFO and sends each byte LSB-first as a serial frame on Tx.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Fifo_Empty,
    input  logic [7:0] Fifo_Data,
    output logic       Fifo_Enable,
    output logic       Fifo_Read_Write,
    output logic       Tx,
    output logic       Busy,
    output logic       Tx_Done
);

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    tx_state_t            state_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic [2:0]           bit_idx_reg;
    logic                 stop_cnt_reg;
    logic                 tx_reg;
    logic                 busy_reg;
    logic                 fifo_en_reg;
    logic                 tick;
    logic                 baud_clear;
    logic                 more;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                 parity_reg;
`endif

    assign more = Run && !Fifo_Empty;

    // The bit timer is held at zero until the frame starts so START gets a full period.
    assign baud_clear = (state_reg == IDLE) || (state_reg == REQ) || (state_reg == LOAD);

    baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .CLK   (CLK),
        .Reset (Reset),
        .Clear (baud_clear),
        .Tick  (tick)
    );

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_reg    <= IDLE;
            shift_reg    <= '0;
            bit_idx_reg  <= '0;
            stop_cnt_reg <= 1'b0;
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b0;
            fifo_en_reg  <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_reg   <= 1'b0;
`endif
        end else begin
            fifo_en_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    tx_reg <= 1'b1;
                    if (more) begin
                        state_reg   <= REQ;
                        fifo_en_reg <= 1'b1;
                        busy_reg    <= 1'b1;
                    end else begin
                        busy_reg <= 1'b0;
                    end
                end
                REQ: begin
                    state_reg <= LOAD;
                end
                LOAD: begin
                    shift_reg    <= Fifo_Data;
`ifdef FIFO_UART_TX_PARITY_EN
                    parity_reg   <= ^Fifo_Data;
`endif
                    bit_idx_reg  <= '0;
                    stop_cnt_reg <= 1'b0;
                    tx_reg       <= 1'b0;
                    state_reg    <= START;
                end
                START: begin
                    if (tick) begin
                        tx_reg    <= shift_reg[0];
                        state_reg <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_reg   <= shift_reg >> 1;
                        bit_idx_reg <= bit_idx_reg + 1'b1;
                        if (bit_idx_reg == LAST_BIT) begin
`ifdef FIFO_UART_TX_PARITY_EN
                            tx_reg    <= parity_reg;
                            state_reg <= PARITY;
`else
                            tx_reg    <= 1'b1;
                            state_reg <= STOP;
`endif
                        end else begin
                            // Output tracks the bit that becomes shift[0] after this shift.
                            tx_reg <= shift_reg[1];
                        end
                    end
                end
`ifdef FIFO_UART_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        tx_reg    <= 1'b1;
                        state_reg <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (stop_cnt_reg == LAST_STOP) begin
                            if (more) begin
                                state_reg   <= REQ;
                                fifo_en_reg <= 1'b1;
                            end else begin
                                state_reg <= IDLE;
                                busy_reg  <= 1'b0;
                            end
                        end else begin
                            stop_cnt_reg <= stop_cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    tx_reg    <= 1'b1;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign Fifo_Enable     = fifo_en_reg;
    assign Fifo_Read_Write = FIFO_RD;
    assign Tx              = tx_reg;
    assign Busy            = busy_reg;
    assign Tx_Done         = (state_reg == STOP) && tick && (stop_cnt_reg == LAST_STOP);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: FIFO model, per-cycle expected waveform, frame-length monitor.
module tb_fifo_uart_tx;

    localparam int CLKS  = 16;
    localparam int STOPB = 2;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int FRAME = (1 + 8 + PBITS + STOPB) * CLKS;

    logic       CLK = 1'b0;
    logic       Reset;
    logic       Run;
    logic       Fifo_Empty;
    logic [7:0] Fifo_Data;
    logic       Fifo_Enable;
    logic       Fifo_Read_Write;
    logic       Tx;
    logic       Busy;
    logic       Tx_Done;

    fifo_uart_tx #(.CLKS_PER_BIT(CLKS), .STOP_BITS(STOPB)) dut (
        .CLK             (CLK),
        .Reset           (Reset),
        .Run             (Run),
        .Fifo_Empty      (Fifo_Empty),
        .Fifo_Data       (Fifo_Data),
        .Fifo_Enable     (Fifo_Enable),
        .Fifo_Read_Write (Fifo_Read_Write),
        .Tx              (Tx),
        .Busy            (Busy),
        .Tx_Done         (Tx_Done)
    );

    always #5 CLK = ~CLK;

    // FIFO model: registered read data, bench owns the write side
    logic [7:0] fifo_mem [0:255];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         pop_count = 0;
    logic [7:0] fifo_q_data = 8'h00;

    assign Fifo_Empty = (wr_ptr == rd_ptr);
    assign Fifo_Data  = fifo_q_data;

    always @(posedge CLK) begin
        if (Fifo_Enable && (Fifo_Read_Write == 1'b0)) begin
            fifo_q_data <= fifo_mem[rd_ptr % 256];
            rd_ptr      <= rd_ptr + 1;
            pop_count   <= pop_count + 1;
        end
    end

    task automatic push(input logic [7:0] d);
        fifo_mem[wr_ptr % 256] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    // Expected per-cycle outputs: {tx, busy, fifo_enable, tx_done, read_write}
    logic [4:0] exp_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    bit         in_frame = 0;
    int         frame_start = 0;
    int         samp = 0;

    function automatic void add_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(5'b10000);
    endfunction

    function automatic void add_frame(input logic [7:0] d, input logic par);
        logic fb[$];
        logic done;
        exp_q.push_back(5'b11100);
        exp_q.push_back(5'b11000);
        fb.push_back(1'b0);
        for (int k = 0; k < 8; k++) fb.push_back(d[k]);
        if (PBITS != 0) fb.push_back(par);
        for (int s = 0; s < STOPB; s++) fb.push_back(1'b1);
        for (int j = 0; j < fb.size(); j++) begin
            for (int c = 0; c < CLKS; c++) begin
                done = (j == fb.size() - 1) && (c == CLKS - 1);
                exp_q.push_back({fb[j], 1'b1, 1'b0, done, 1'b0});
            end
        end
    endfunction

    task automatic cmp(input string tag, input int idx, input logic [4:0] exp);
        logic [4:0] act;
        act = {Tx, Busy, Fifo_Enable, Tx_Done, Fifo_Read_Write};
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d]: tx,busy,en,done,rw = %b, want %b", tag, idx, act, exp);
        end
    endtask

    task automatic cmp_int(input string tag, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    task automatic check_cycles(input string tag, input int n);
        logic [4:0] e;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            samp++;
            e = (exp_q.size() == 0) ? 5'b10000 : exp_q.pop_front();
            cmp(tag, i, e);
            if (!in_frame && Tx == 1'b0) begin
                in_frame    = 1;
                frame_start = samp;
            end
            if (Tx_Done) begin
                cmp_int({tag, "_frame_len"}, in_frame ? (samp - frame_start + 1) : 0, FRAME);
                in_frame = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check_cycles(tag, exp_q.size());
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int p0;
        int n;
        logic [7:0] d;

        tbl[0] = '{8'hA5, 1'b0};
        tbl[1] = '{8'h07, 1'b1};
        tbl[2] = '{8'h03, 1'b0};
        tbl[3] = '{8'h80, 1'b1};
        tbl[4] = '{8'h00, 1'b0};

        // Reset with Run high and FIFO empty
        Reset = 1'b1;
        Run   = 1'b1;
        #2;
        cmp("reset", 0, 5'b10000);
        repeat (3) @(negedge CLK);
        Reset = 1'b0;
        add_idle(100);
        check_all("idle_empty");
        cmp_int("idle_pops", pop_count, 0);

        // Single-byte frames from the table
        for (int t = 0; t < 5; t++) begin
            p0 = pop_count;
            push(tbl[t].data);
            add_frame(tbl[t].data, tbl[t].par);
            add_idle(4);
            check_all($sformatf("byte_%02h", tbl[t].data));
            cmp_int($sformatf("pops_%02h", tbl[t].data), pop_count - p0, 1);
        end

        // Three queued bytes back to back
        p0 = pop_count;
        push(8'h01); push(8'hFF); push(8'h3C);
        add_frame(8'h01, 1'b1);
        add_frame(8'hFF, 1'b0);
        add_frame(8'h3C, 1'b0);
        add_idle(6);
        check_all("b2b");
        cmp_int("b2b_pops", pop_count - p0, 3);

        // Reset in the middle of data bit 4 of 0xF0; next byte must go out intact
        push(8'hF0); push(8'h5A);
        add_frame(8'hF0, 1'b0);
        check_cycles("pre_reset", 2 + CLKS * 5 + CLKS / 2);
        Reset = 1'b1;
        #1;
        cmp("async_reset", 0, 5'b10000);
        @(negedge CLK);
        cmp("reset_hold", 0, 5'b10000);
        Reset    = 1'b0;
        in_frame = 0;
        exp_q.delete();
        add_frame(8'h5A, 1'b0);
        add_idle(4);
        check_all("post_reset");
        cmp_int("post_reset_ptr", rd_ptr, wr_ptr);

        // Run dropped during DATA with two bytes queued
        p0 = pop_count;
        push(8'h96); push(8'h3B);
        add_frame(8'h96, 1'b0);
        add_idle(40);
        check_cycles("run_drop", 2 + CLKS * 3);
        Run = 1'b0;
        check_all("run_drop");
        cmp_int("run_drop_pops", pop_count - p0, 1);
        Run = 1'b1;
        add_frame(8'h3B, 1'b1);
        add_idle(4);
        check_all("run_resume");
        cmp_int("run_resume_empty", int'(Fifo_Empty), 1);

        // Randomized bursts with Run gating; parity from the even-parity rule
        for (int r = 0; r < 6; r++) begin
            Run = 1'b0;
            n   = $urandom_range(1, 3);
            p0  = pop_count;
            for (int k = 0; k < n; k++) begin
                d = 8'($urandom_range(0, 255));
                push(d);
                add_frame(d, ^d);
            end
            exp_q.delete();
            add_idle($urandom_range(1, 6));
            check_all("rand_gated");
            Run = 1'b1;
            for (int k = 0; k < n; k++) begin
                d = fifo_mem[(wr_ptr - n + k) % 256];
                add_frame(d, ^d);
            end
            add_idle(3);
            check_all($sformatf("rand_%0d", r));
            cmp_int($sformatf("rand_pops_%0d", r), pop_count - p0, n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
